wb_ram_slave: RTL and testbench
===============================

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  adr_width 32 byte-address width
  dat_width 32 data width, multiple of 8
  sel_width dat_width/8 byte-select width
  depth 1024 storage size in words, power of two
  base_adr 0 byte address of word 0, depth-aligned
  wait_states 0 extra cycles before response, 0..15
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clock input 1 clock, rising edge
  reset input 1 reset, synchronous, active-high
  cyc input 1 bus cycle active
  stb input 1 transfer strobe
  we input 1 1 = write, 0 = read
  adr input adr_width byte address
  datwr input dat_width write data
  sel input sel_width byte-lane enables
  datrd output dat_width read data
  ack output 1 normal termination
  err output 1 error termination
REQ-003 Reset SHALL be exactly: reset reset, synchronous, active-high; clock clock.

Function
REQ-004 The block SHALL be a Wishbone classic-cycle responder: one outstanding transfer, single-cycle ack/err pulse per transfer.
REQ-005 FSM states SHALL be IDLE, WAIT, RESP.
REQ-006 IDLE: on cyc&stb at edge N, the block SHALL latch we/adr/datwr/sel; go to RESP if wait_states=0, else WAIT with counter loaded to wait_states-1.
REQ-007 WAIT: counter decrements each cycle; at 0 go to RESP.
REQ-008 RESP: exactly one of ack/err SHALL be high for one cycle; next state IDLE; response cycle = N+1+wait_states.
REQ-009 Inputs SHALL NOT be sampled in WAIT or RESP; back-to-back transfers start no earlier than the cycle after RESP (max throughput one transfer per 2+wait_states cycles).
REQ-010 Decode: off = adr - base_adr (adr_width modulo); word index = off >> log2(sel_width).
REQ-011 Out-of-range (off >= depth*sel_width) or misaligned (low log2(sel_width) adr bits nonzero) transfers SHALL respond with err=1, ack=0; no storage change; datrd=0.
REQ-012 Valid write SHALL update only the byte lanes with sel[b]=1, committed on the RESP edge; sel=0 SHALL complete with ack and no change.
REQ-013 Valid read SHALL drive datrd with the full word during RESP, regardless of sel; datrd SHALL be 0 whenever ack is 0.
REQ-014 A read of a word written by the immediately preceding transfer SHALL return the new data.
REQ-015 Abort: cyc=0 in WAIT SHALL return to IDLE next edge, no write, no ack/err; cyc=0 in RESP SHALL still complete the one-cycle pulse with the write committed.
REQ-016 ack and err SHALL never be high simultaneously nor in consecutive cycles.

Reset
REQ-017 reset=1 SHALL force state IDLE, counter 0, ack=0, err=0, datrd=0 at the next edge, overriding any transfer in progress (pending write discarded).
REQ-018 Storage contents SHALL NOT be cleared by reset; reads of never-written words return undefined data.
REQ-019 First transfer SHALL be accepted on the first edge with reset=0 and cyc&stb=1.

Verification
REQ-020 wait_states=0: write adr 0x10 datwr 0xDEADBEEF sel 0xF, then read 0x10 -> ack one cycle after each request, datrd=0xDEADBEEF.
REQ-021 Byte lanes: write 0x0 with 0x11223344, then 0xAABBCCDD sel 0x5, read -> 0x11BB33DD.
REQ-022 wait_states=3: read request at edge N -> ack exactly at N+4, low at N+1..N+3 and N+5.
REQ-023 Errors (depth 1024, base 0): adr 0x1000 -> err=1 ack=0; adr 0x2 -> err=1; subsequent read of written address unchanged.
REQ-024 Abort: wait_states=3, write 0x20 := 0x5, drop cyc at N+2 -> no ack/err; read 0x20 returns prior value.
REQ-025 Reset mid-transfer: assert reset during WAIT -> ack/err stay 0, FSM IDLE, write not committed; next transfer after reset completes normally.

Source files
------------

// File: rtl/wb_ram_slave_if.sv
// Wishbone classic-cycle bus bundle between a master and the wb_ram_slave responder.
interface wb_ram_slave_if #(
  parameter int adr_width = 32,
  parameter int dat_width = 32,
  parameter int sel_width = dat_width / 8
);
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [adr_width-1:0] adr;
  logic [dat_width-1:0] datwr;
  logic [sel_width-1:0] sel;
  logic [dat_width-1:0] datrd;
  logic                 ack;
  logic                 err;

  modport master (
    output cyc, stb, we, adr, datwr, sel,
    input  datrd, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, datwr, sel,
    output datrd, ack, err
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone classic-cycle RAM responder: one outstanding transfer, optional wait
// states, byte-lane writes, err termination for out-of-range or misaligned access.
module wb_ram_slave #(
  parameter int adr_width   = 32,
  parameter int dat_width   = 32,
  parameter int sel_width   = dat_width / 8,
  parameter int depth       = 1024,
  parameter int base_adr    = 0,
  parameter int wait_states = 0
) (
  input logic          clock,
  input logic          reset,
  wb_ram_slave_if.slave bus
);

  localparam int lsb_w  = $clog2(sel_width);
  localparam int idx_w  = $clog2(depth);
  localparam int span_w = lsb_w + idx_w;
  localparam logic [adr_width-1:0] base_v   = adr_width'(base_adr);
  localparam logic [adr_width-1:0] lsb_mask = adr_width'((64'd1 << lsb_w) - 64'd1);
  localparam logic [3:0]           ws_load  = (wait_states == 0) ? 4'd0 : 4'(wait_states - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_r;
  logic [3:0]           cnt_r;
  logic                 we_r;
  logic                 valid_r;
  logic [idx_w-1:0]     idx_r;
  logic [dat_width-1:0] datwr_r;
  logic [sel_width-1:0] sel_r;
  logic                 ack_r;
  logic                 err_r;
  logic [dat_width-1:0] datrd_r;

  logic [dat_width-1:0] mem_r [0:depth-1];

  logic [adr_width-1:0] off_s;
  logic                 valid_s;
  logic [idx_w-1:0]     idx_s;
  logic [idx_w-1:0]     rd_idx_s;
  logic [dat_width-1:0] rd_word_s;

  // Address decode of the live bus request and read-port index selection
  always_comb begin
    off_s   = bus.adr - base_v;
    valid_s = ((off_s >> span_w) == {adr_width{1'b0}}) &&
              ((bus.adr & lsb_mask) == {adr_width{1'b0}});
    idx_s   = off_s[lsb_w +: idx_w];
    // Zero-wait transfers read with the live index; delayed ones use the latched index
    if (state_r == IDLE) begin
      rd_idx_s = idx_s;
    end else begin
      rd_idx_s = idx_r;
    end
    rd_word_s = mem_r[rd_idx_s];
  end

  // Transfer FSM with registered ack/err/datrd
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      valid_r <= 1'b0;
      idx_r   <= {idx_w{1'b0}};
      datwr_r <= {dat_width{1'b0}};
      sel_r   <= {sel_width{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      datrd_r <= {dat_width{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          datrd_r <= {dat_width{1'b0}};
          if (bus.cyc && bus.stb) begin
            we_r    <= bus.we;
            valid_r <= valid_s;
            idx_r   <= idx_s;
            datwr_r <= bus.datwr;
            sel_r   <= bus.sel;
            if (wait_states == 0) begin
              state_r <= RESP;
              ack_r   <= valid_s;
              err_r   <= !valid_s;
              datrd_r <= (valid_s && !bus.we) ? rd_word_s : {dat_width{1'b0}};
            end else begin
              state_r <= WAIT;
              cnt_r   <= ws_load;
            end
          end
        end
        WAIT: begin
          if (!bus.cyc) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end else if (cnt_r == 4'd0) begin
            state_r <= RESP;
            ack_r   <= valid_r;
            err_r   <= !valid_r;
            datrd_r <= (valid_r && !we_r) ? rd_word_s : {dat_width{1'b0}};
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          datrd_r <= {dat_width{1'b0}};
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          datrd_r <= {dat_width{1'b0}};
        end
      endcase
    end
  end

  // Byte-lane write commit on the edge that ends the response cycle; storage is never reset
  always_ff @(posedge clock) begin
    if (!reset && (state_r == RESP) && we_r && valid_r) begin
      for (int b = 0; b < sel_width; b++) begin
        if (sel_r[b]) begin
          mem_r[idx_r][8*b +: 8] <= datwr_r[8*b +: 8];
        end
      end
    end
  end

  assign bus.ack   = ack_r;
  assign bus.err   = err_r;
  assign bus.datrd = datrd_r;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: a zero-wait and a three-wait instance.
module tb_wb_ram_slave;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  wb_ram_slave_if #(.adr_width(32), .dat_width(32), .sel_width(4)) bus0 ();
  wb_ram_slave_if #(.adr_width(32), .dat_width(32), .sel_width(4)) bus1 ();

  wb_ram_slave #(.adr_width(32), .dat_width(32), .sel_width(4), .depth(1024),
                 .base_adr(0), .wait_states(0)) u_dut0 (
    .clock(clock), .reset(reset), .bus(bus0));

  wb_ram_slave #(.adr_width(32), .dat_width(32), .sel_width(4), .depth(1024),
                 .base_adr(0), .wait_states(3)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    int          latency;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] model0 [int];
  logic [31:0] model1 [int];
  int          errors = 0;
  int          checks = 0;

  task automatic set_bus(input int d, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] dat, input logic [3:0] sl);
    if (d == 0) begin
      bus0.cyc = c; bus0.stb = s; bus0.we = w; bus0.adr = a; bus0.datwr = dat; bus0.sel = sl;
    end else begin
      bus1.cyc = c; bus1.stb = s; bus1.we = w; bus1.adr = a; bus1.datwr = dat; bus1.sel = sl;
    end
  endtask

  task automatic get_resp(input int d, output logic ak, output logic er, output logic [31:0] rd);
    if (d == 0) begin
      ak = bus0.ack; er = bus0.err; rd = bus0.datrd;
    end else begin
      ak = bus1.ack; er = bus1.err; rd = bus1.datrd;
    end
  endtask

  // Reference model: decode, byte-lane merge, expected response pushed to the scoreboard
  task automatic predict(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] sl);
    exp_t        x;
    logic [31:0] word;
    logic        ok;
    int          idx;
    ok        = (a < 32'h0000_1000) && (a[1:0] == 2'b00);
    idx       = int'(a >> 2);
    x.latency = (d == 0) ? 1 : 4;
    x.is_err  = !ok;
    x.data    = 32'h0;
    if (ok) begin
      word = 32'h0;
      if (d == 0 && model0.exists(idx)) word = model0[idx];
      if (d == 1 && model1.exists(idx)) word = model1[idx];
      if (w) begin
        for (int b = 0; b < 4; b++) if (sl[b]) word[8*b +: 8] = dat[8*b +: 8];
        if (d == 0) model0[idx] = word;
        else model1[idx] = word;
      end else begin
        x.data = word;
      end
    end
    sb_q.push_back(x);
  endtask

  // Entered and left at a negedge; next request may be driven immediately on return
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] dat, input logic [3:0] sl, input string tag);
    exp_t        x;
    logic        ak, er;
    logic [31:0] rd;
    int          k;
    bit          seen;
    predict(d, w, a, dat, sl);
    set_bus(d, 1'b1, 1'b1, w, a, dat, sl);
    @(posedge clock);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 40) begin
      @(negedge clock);
      k++;
      get_resp(d, ak, er, rd);
      if (ak || er) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (rd !== 32'h0) begin
          errors++;
          $display("FAIL %s idle_datrd: cycle %0d datrd=%h, required 00000000", tag, k, rd);
        end
      end
    end
    set_bus(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    x = sb_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no ack/err within %0d cycles, required latency %0d", tag, k, x.latency);
    end else begin
      checks++;
      if (k !== x.latency) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles, required %0d", tag, k, x.latency);
      end
      checks++;
      if (ak !== !x.is_err || er !== x.is_err) begin
        errors++;
        $display("FAIL %s resp: ack=%b err=%b, required ack=%b err=%b", tag, ak, er, !x.is_err, x.is_err);
      end
      checks++;
      if (rd !== x.data) begin
        errors++;
        $display("FAIL %s datrd: got %h, required %h", tag, rd, x.data);
      end
    end
    @(negedge clock);
    get_resp(d, ak, er, rd);
    checks++;
    if (ak !== 1'b0 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL %s after_pulse: ack=%b err=%b datrd=%h, required 0 0 00000000", tag, ak, er, rd);
    end
  endtask

  task automatic expect_quiet(input int d, input int n, input string tag);
    logic        ak, er;
    logic [31:0] rd;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      get_resp(d, ak, er, rd);
      checks++;
      if (ak !== 1'b0 || er !== 1'b0 || rd !== 32'h0) begin
        errors++;
        $display("FAIL %s quiet: cycle %0d ack=%b err=%b datrd=%h, required 0 0 00000000", tag, i, ak, er, rd);
      end
    end
  endtask

  task automatic test_reset();
    logic        ak, er;
    logic [31:0] rd;
    reset = 1'b1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      get_resp(d, ak, er, rd);
      checks++;
      if (ak !== 1'b0 || er !== 1'b0 || rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ack=%b err=%b datrd=%h, required 0 0 00000000", d, ak, er, rd);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "basic_wr0");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, "basic_rd0");
    xfer(1, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, "basic_wr1");
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, "basic_rd1_sel0");
  endtask

  task automatic test_byte_lanes();
    xfer(0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, "lane_full");
    xfer(0, 1'b1, 32'h0, 32'hAABB_CCDD, 4'h5, "lane_sel5");
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, "lane_rd");
    xfer(0, 1'b1, 32'h0, 32'h5555_5555, 4'h0, "lane_sel0");
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h1, "lane_rd2");
    xfer(1, 1'b1, 32'h4, 32'h0102_0304, 4'hA, "lane_selA_w3");
    xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, "lane_rd_w3");
  endtask

  task automatic test_wait_states();
    xfer(1, 1'b1, 32'h100, 32'h8765_4321, 4'hF, "ws3_wr");
    xfer(1, 1'b0, 32'h100, 32'h0, 4'hF, "ws3_rd");
  endtask

  task automatic test_errors();
    xfer(0, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, "err_setup");
    xfer(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, "err_range_wr");
    xfer(0, 1'b1, 32'h42, 32'hFFFF_FFFF, 4'hF, "err_misalign_wr");
    xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, "err_range_rd");
    xfer(0, 1'b0, 32'h2, 32'h0, 4'hF, "err_misalign_rd");
    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, "err_unchanged");
    xfer(0, 1'b1, 32'hFFC, 32'h7777_1234, 4'hF, "top_word_wr");
    xfer(0, 1'b0, 32'hFFC, 32'h0, 4'hF, "top_word_rd");
    xfer(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, "err_wrap");
    xfer(1, 1'b0, 32'h2000, 32'h0, 4'hF, "err_ws3");
  endtask

  task automatic test_abort();
    xfer(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, "abort_setup");
    set_bus(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h0000_0005, 4'hF);
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_quiet(1, 8, "abort");
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, "abort_rd");
  endtask

  task automatic test_reset_mid();
    xfer(1, 1'b1, 32'h30, 32'h0000_1111, 4'hF, "rst_setup");
    set_bus(1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h0000_CAFE, 4'hF);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    expect_quiet(1, 2, "rst_active");
    reset = 1'b0;
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expect_quiet(1, 6, "rst_after");
    xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, "rst_rd");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, "rst_keeps_mem");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, 32'h80 + 32'(4*i), 32'hA5A5_0000 + 32'(i), 4'hF, "b2b_wr");
      xfer(0, 1'b0, 32'h80 + 32'(4*i), 32'h0, 4'hF, "b2b_rd");
    end
    xfer(1, 1'b1, 32'h200, $urandom, 4'(($urandom % 15) + 1), "b2b_rand_wr");
    xfer(1, 1'b0, 32'h200, 32'h0, 4'hF, "b2b_rand_rd");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
